// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexes six BCD digits onto a common-segment 7-segment display.
//   Digits are snapshotted once per frame (on the index 5->0 wrap) so a frame
//   never mixes old and new time values. Supports a blinking edit digit,
//   leading-zero blanking of hr_10 and a dash for non-BCD codes.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   hr_10 .. sec_1       BCD digits from the time source
//   blink_sel            1..6 blinks digit index 0..5; 0/7 = no blink
//   dp_mask              bit k lights the decimal point of digit k
//   blank_lz             blank hr_10 when its snapshot value is 0
//   an[7:0]              anode enables (an[5:0] digits, an[7:6] never active)
//   seg[6:0]             {g,f,e,d,c,b,a}
//   dp                   decimal point
//   Pin polarity set by ACTIVE_LOW; outputs are registered (1 cycle latency).
module seg7_scan_driver #(
    parameter int SCAN_DIV   = 100000,
    parameter int DEAD_CYC   = 2,
    parameter int BLINK_DIV  = 25000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hr_10,
    input  logic [3:0] hr_1,
    input  logic [3:0] min_10,
    input  logic [3:0] min_1,
    input  logic [3:0] sec_10,
    input  logic [3:0] sec_1,
    input  logic [2:0] blink_sel,
    input  logic [5:0] dp_mask,
    input  logic       blank_lz,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int   SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int   BLW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [SCW-1:0]  scan_cnt;
    logic [2:0]      idx;
    logic [BLW-1:0]  blink_cnt;
    logic            phase;        // 1 = blinking digit currently dark
    logic [2:0]      blink_sel_q;
    logic [5:0][3:0] snap;         // [5]=hr_10 ... [0]=sec_1

    logic            scan_tc;
    logic            blink_tc;
    logic [3:0]      digit;
    logic            in_dead;
    logic            blank_blink;
    logic            blank_zero;
    logic            lit;
    logic [7:0]      an_h;
    logic [6:0]      seg_h;
    logic            dp_h;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;   // non-BCD shows a dash
        endcase
    endfunction

    always_comb begin
        scan_tc     = (scan_cnt == SCW'(SCAN_DIV - 1));
        blink_tc    = (blink_cnt == BLW'(BLINK_DIV - 1));
        digit       = snap[idx];
        // signed compare so DEAD_CYC=0 simply never matches
        in_dead     = (int'(scan_cnt) < DEAD_CYC);
        blank_blink = phase && (blink_sel != 3'd0) && (blink_sel != 3'd7) &&
                      (idx == blink_sel - 3'd1);
        blank_zero  = (idx == 3'd5) && blank_lz && (snap[5] == 4'd0);
        lit         = !in_dead && !blank_blink && !blank_zero;
        an_h        = 8'd0;
        seg_h       = 7'd0;
        dp_h        = 1'b0;
        if (lit) begin
            an_h  = 8'd1 << idx;
            seg_h = decode(digit);
            dp_h  = dp_mask[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt    <= '0;
            idx         <= 3'd0;
            blink_cnt   <= '0;
            phase       <= 1'b0;
            blink_sel_q <= 3'd0;
            snap        <= '0;
            an          <= {8{INV}};
            seg         <= {7{INV}};
            dp          <= INV;
        end else begin
            if (scan_tc) begin
                scan_cnt <= '0;
                idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
                // capture on the same edge as the wrap so slot 0 of the
                // new frame already shows new data
                if (idx == 3'd5)
                    snap <= {hr_10, hr_1, min_10, min_1, sec_10, sec_1};
            end else begin
                scan_cnt <= scan_cnt + SCW'(1);
            end

            // a new blink target restarts visible, even on a terminal count
            blink_sel_q <= blink_sel;
            if (blink_sel != blink_sel_q) begin
                blink_cnt <= '0;
                phase     <= 1'b0;
            end else if (blink_tc) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BLW'(1);
            end

            an  <= an_h ^ {8{INV}};
            seg <= seg_h ^ {7{INV}};
            dp  <= dp_h ^ INV;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (SCAN_DIV=8, DEAD_CYC=2,
// BLINK_DIV=64, ACTIVE_LOW=1). Each negedge the reference predicts the pins
// the next posedge will register and queues it; the following negedge pops
// and compares against {an,seg,dp}.
module tb_seg7_scan_driver;

    localparam int SD = 8;
    localparam int DC = 2;
    localparam int BD = 64;
    localparam int FR = 6 * SD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] hr_10, hr_1, min_10, min_1, sec_10, sec_1;
    logic [2:0] blink_sel;
    logic [5:0] dp_mask;
    logic       blank_lz;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    seg7_scan_driver #(
        .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_DIV(BD), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset),
        .hr_10(hr_10), .hr_1(hr_1), .min_10(min_10), .min_1(min_1),
        .sec_10(sec_10), .sec_1(sec_1),
        .blink_sel(blink_sel), .dp_mask(dp_mask), .blank_lz(blank_lz),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        return tbl[d];
    endfunction

    // reference state: t = cycles since reset, snapshot, blink restart time
    int          t = 0;
    int          cyc = 0;
    int          bl_t0 = 0;
    logic [2:0]  m_prev = 3'd0;
    logic [3:0]  m_snap [6];
    logic [15:0] exp_q [$];
    bit          mon_en = 1'b1;

    always @(negedge clk) begin
        logic [15:0] e;
        logic [3:0]  cur [6];
        logic [3:0]  d;
        int          slot, pos;
        bit          lit;
        if (mon_en) begin
            cyc++;
            if (exp_q.size() > 0) begin
                chk($sformatf("pins@%0d", cyc), {an, seg, dp}, exp_q.pop_front());
                chk($sformatf("an76@%0d", cyc), {14'd0, an[7:6]}, 16'd3);
            end
            if (reset) begin
                e = 16'hFFFF;
                t = 0;
                bl_t0 = 0;
                m_prev = 3'd0;
                foreach (m_snap[i]) m_snap[i] = 4'd0;
            end else begin
                slot = (t / SD) % 6;
                pos  = t % SD;
                d    = m_snap[slot];
                lit  = (pos >= DC);
                if (blink_sel >= 3'd1 && blink_sel <= 3'd6 &&
                    (((t - bl_t0) / BD) % 2 == 1) && slot == int'(blink_sel) - 1)
                    lit = 1'b0;
                if (slot == 5 && blank_lz && d == 4'd0)
                    lit = 1'b0;
                if (lit) e = {~(8'd1 << slot), ~ref_seg(d), ~dp_mask[slot]};
                else     e = 16'hFFFF;
                cur = '{sec_1, sec_10, min_1, min_10, hr_1, hr_10};
                if (t % FR == FR - 1) m_snap = cur;
                if (blink_sel != m_prev) bl_t0 = t + 1;
                m_prev = blink_sel;
                t++;
            end
            exp_q.push_back(e);
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        {hr_10, hr_1, min_10, min_1, sec_10, sec_1} = '0;
        blink_sel = 3'd0;
        dp_mask   = 6'd0;
        blank_lz  = 1'b0;

        // reset held 3 cycles; first frame must show the zero snapshot
        run(3);
        chk("reset_pins", {an, seg, dp}, 16'hFFFF);
        reset = 1'b0;
        hr_10 = 4'd1; hr_1 = 4'd2; min_10 = 4'd3;
        min_1 = 4'd4; sec_10 = 4'd5; sec_1 = 4'd6;
        run(96);

        // mid-frame input change: visible only from the next frame
        run(10);
        min_1 = 4'd9;
        run(100);

        dp_mask = 6'b101011;
        run(48);

        // blink digit 2, then move to digit 3 while phase is dark
        blink_sel = 3'd3;
        run(200);
        blink_sel = 3'd4;
        run(200);

        // change lands exactly on a blink terminal count
        blink_sel = 3'd3;
        run(64);
        blink_sel = 3'd2;
        run(150);

        blink_sel = 3'd0;
        dp_mask   = 6'd0;
        sec_1     = 4'hC;
        run(96);

        hr_10    = 4'd0;
        blank_lz = 1'b1;
        run(96);
        blank_lz = 1'b0;
        run(96);

        // reset in the middle of a frame
        run(21);
        reset = 1'b1;
        run(2);
        chk("midrst_pins", {an, seg, dp}, 16'hFFFF);
        reset = 1'b0;
        run(100);

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
